reg_writeback: RTL and testbench

//  Writeback stage directly upstream of the register file. Merges single-cycle ALU

---
 rtl/toast_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 43 ++++
 rtl/reg_writeback.sv | 111 +++++++++++
 tb/tb_reg_writeback.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/toast_pkg.sv
// rtl/toast_pkg.sv - shared types and register-map helpers for the writeback stage
package toast_pkg;

    localparam int WB_DATA_W = 16;
    localparam int WB_ADDR_W = 4;

    typedef logic [WB_ADDR_W-1:0] reg_addr_t;
    typedef logic [WB_DATA_W-1:0] data_t;

    localparam reg_addr_t REG_ISR = 4'hC;
    localparam reg_addr_t REG_SP  = 4'hD;
    localparam reg_addr_t REG_SR  = 4'hE;
    localparam reg_addr_t REG_PC  = 4'hF;

    typedef struct packed {
        reg_addr_t addr;
        data_t     data;
    } wb_entry_t;

    // SP/SR/PC sit above ISR and are owned by dedicated hardware, never the write port.
    function automatic logic reg_writable(input reg_addr_t addr);
        return addr <= REG_ISR;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - skid FIFO holding load returns that lost the commit slot
module wb_fifo
    import toast_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clock,
    input  logic      reset_n,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int          PW      = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    // The extra MSB on each pointer tells full apart from empty when the indices match.
    logic [PW:0] wr_ptr_q, rd_ptr_q;
    wb_entry_t   mem_q [DEPTH];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                     (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (push_i) mem_q[wr_ptr_q[PW-1:0]] <= push_entry_i;
    end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - merges ALU results and load returns into one registered write port
module reg_writeback
    import toast_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int DATA_W     = WB_DATA_W,
    parameter int ADDR_W     = WB_ADDR_W
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              load_issue,
    input  logic [ADDR_W-1:0] load_issue_addr,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [15:0]       busy,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_addr,
    output logic [DATA_W-1:0] write_data,
    output logic              protocol_err
);

    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    wb_entry_t   fifo_head, mem_entry, commit_entry;
    logic        mem_accept, commit_valid, commit_is_load;
    logic        issue_ok, commit_clr;
    logic [15:0] busy_q, busy_d;
    logic        err_q, err_d;
    logic        write_en_q, write_en_d;
    wb_entry_t   write_q, write_d;

    assign mem_entry  = '{addr: mem_addr, data: mem_data};
    assign mem_ready  = !fifo_full;
    assign mem_accept = mem_valid && !fifo_full;
    // A beat bypasses only when it wins the slot outright; anything else waits in the FIFO.
    assign fifo_push  = mem_accept && (alu_valid || !fifo_empty);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock       (clock),
        .reset_n     (reset_n),
        .push_i      (fifo_push),
        .push_entry_i(mem_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        commit_valid   = 1'b0;
        commit_is_load = 1'b0;
        commit_entry   = '0;
        fifo_pop       = 1'b0;
        if (alu_valid) begin
            commit_valid = 1'b1;
            commit_entry = '{addr: alu_addr, data: alu_data};
        end else if (!fifo_empty) begin
            commit_valid   = 1'b1;
            commit_is_load = 1'b1;
            commit_entry   = fifo_head;
            fifo_pop       = 1'b1;
        end else if (mem_accept) begin
            commit_valid   = 1'b1;
            commit_is_load = 1'b1;
            commit_entry   = mem_entry;
        end
    end

    assign issue_ok   = load_issue && reg_writable(load_issue_addr);
    assign commit_clr = commit_is_load && reg_writable(commit_entry.addr);

    always_comb begin
        busy_d = busy_q;
        if (commit_clr) busy_d[commit_entry.addr] = 1'b0;
        if (issue_ok)   busy_d[load_issue_addr]   = 1'b1;

        err_d = err_q
              | (issue_ok && busy_q[load_issue_addr])
              | (alu_valid && busy_q[alu_addr])
              | (mem_accept && reg_writable(mem_addr) && !busy_q[mem_addr])
              | (issue_ok && commit_clr && (commit_entry.addr == load_issue_addr));

        write_en_d = commit_valid && reg_writable(commit_entry.addr);
        write_d    = write_en_d ? commit_entry : write_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q     <= '0;
            err_q      <= 1'b0;
            write_en_q <= 1'b0;
            write_q    <= '0;
        end else begin
            busy_q     <= busy_d;
            err_q      <= err_d;
            write_en_q <= write_en_d;
            write_q    <= write_d;
        end
    end

    assign busy         = busy_q;
    assign protocol_err = err_q;
    assign write_en     = write_en_q;
    assign write_addr   = write_q.addr;
    assign write_data   = write_q.data;

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - directed self-checking bench for reg_writeback
module tb_reg_writeback;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        alu_valid;
    logic [3:0]  alu_addr;
    logic [15:0] alu_data;
    logic        load_issue;
    logic [3:0]  load_issue_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [15:0] mem_data;
    logic [15:0] busy;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        protocol_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    reg_writeback dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .alu_valid      (alu_valid),
        .alu_addr       (alu_addr),
        .alu_data       (alu_data),
        .load_issue     (load_issue),
        .load_issue_addr(load_issue_addr),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .busy           (busy),
        .write_en       (write_en),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .protocol_err   (protocol_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        load_issue = 1'b0; load_issue_addr = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] a, input logic [15:0] d);
        check({tag, "_en"}, write_en, en);
        if (en) begin
            check({tag, "_addr"}, write_addr, a);
            check({tag, "_data"}, write_data, d);
        end
    endtask

    initial begin
        idle();
        reset_n = 1'b0;
        tick(); tick();
        check("rst_we", write_en, 1'b0);
        check("rst_wa", write_addr, 4'h0);
        check("rst_wd", write_data, 16'h0);
        check("rst_busy", busy, 16'h0);
        check("rst_err", protocol_err, 1'b0);
        check("rst_ready", mem_ready, 1'b1);
        reset_n = 1'b1;
        tick();

        // ALU path
        alu_valid = 1'b1; alu_addr = 4'h3; alu_data = 16'hBEEF;
        tick(); idle();
        check_wr("alu", 1'b1, 4'h3, 16'hBEEF);
        tick();
        check("alu_we_drop", write_en, 1'b0);

        // Load round trip
        load_issue = 1'b1; load_issue_addr = 4'h5;
        tick(); idle();
        check("ld_busy_set", busy, 16'h0020);
        mem_valid = 1'b1; mem_addr = 4'h5; mem_data = 16'h1234;
        #1 check("ld_ready", mem_ready, 1'b1);
        tick(); idle();
        check_wr("ld", 1'b1, 4'h5, 16'h1234);
        check("ld_busy_clr", busy, 16'h0);

        // Contention: ALU wins, two loads queue up, then drain in order
        load_issue = 1'b1; load_issue_addr = 4'h1; tick();
        load_issue_addr = 4'h2; tick(); idle();
        check("ct_busy", busy, 16'h0006);
        alu_valid = 1'b1; alu_addr = 4'h8; alu_data = 16'hA001;
        mem_valid = 1'b1; mem_addr = 4'h1; mem_data = 16'h1111;
        #1 check("ct_ready0", mem_ready, 1'b1);
        tick();
        check_wr("ct_alu0", 1'b1, 4'h8, 16'hA001);
        alu_addr = 4'h9; alu_data = 16'hA002;
        mem_addr = 4'h2; mem_data = 16'h2222;
        #1 check("ct_ready1", mem_ready, 1'b1);
        tick();
        check_wr("ct_alu1", 1'b1, 4'h9, 16'hA002);
        mem_valid = 1'b0;
        alu_addr = 4'hA; alu_data = 16'hA003;
        #1 check("ct_full", mem_ready, 1'b0);
        tick(); idle();
        check_wr("ct_alu2", 1'b1, 4'hA, 16'hA003);
        tick();
        check_wr("ct_q1", 1'b1, 4'h1, 16'h1111);
        check("ct_busy1", busy, 16'h0004);
        check("ct_ready2", mem_ready, 1'b1);
        tick();
        check_wr("ct_q2", 1'b1, 4'h2, 16'h2222);
        check("ct_busy2", busy, 16'h0);
        check("ct_err", protocol_err, 1'b0);

        // Read-only targets and the ISR boundary
        alu_valid = 1'b1; alu_addr = 4'hE; alu_data = 16'h5555;
        tick(); idle();
        check("ro_alu", write_en, 1'b0);
        mem_valid = 1'b1; mem_addr = 4'hF; mem_data = 16'h6666;
        tick(); idle();
        check("ro_mem", write_en, 1'b0);
        load_issue = 1'b1; load_issue_addr = 4'hD;
        tick(); idle();
        check("ro_busy", busy, 16'h0);
        check("ro_err", protocol_err, 1'b0);
        load_issue = 1'b1; load_issue_addr = 4'hC;
        tick(); idle();
        check("isr_busy", busy, 16'h1000);
        mem_valid = 1'b1; mem_addr = 4'hC; mem_data = 16'hCCCC;
        tick(); idle();
        check_wr("isr", 1'b1, 4'hC, 16'hCCCC);
        check("isr_clr", busy, 16'h0);

        // Hazards
        load_issue = 1'b1; load_issue_addr = 4'h7;
        tick();
        check("hz_busy", busy, 16'h0080);
        check("hz_err0", protocol_err, 1'b0);
        tick(); idle();
        check("hz_err1", protocol_err, 1'b1);
        alu_valid = 1'b1; alu_addr = 4'h7; alu_data = 16'h7777;
        tick(); idle();
        check_wr("hz_waw", 1'b1, 4'h7, 16'h7777);
        tick(); tick();
        check("hz_sticky", protocol_err, 1'b1);

        // Reset mid-traffic with a queued return
        alu_valid = 1'b1; alu_addr = 4'h0; alu_data = 16'h0A0A;
        mem_valid = 1'b1; mem_addr = 4'h7; mem_data = 16'h7070;
        tick();
        reset_n = 1'b0;
        #1;
        check("mr_we", write_en, 1'b0);
        check("mr_wa", write_addr, 4'h0);
        check("mr_wd", write_data, 16'h0);
        check("mr_busy", busy, 16'h0);
        check("mr_err", protocol_err, 1'b0);
        check("mr_ready", mem_ready, 1'b1);
        tick(); idle(); tick();
        reset_n = 1'b1;
        tick();
        check("mr_nowb0", write_en, 1'b0);
        tick();
        check("mr_nowb1", write_en, 1'b0);

        // Return to a register with no outstanding load still writes but flags an error
        mem_valid = 1'b1; mem_addr = 4'h3; mem_data = 16'h3333;
        tick(); idle();
        check_wr("nb", 1'b1, 4'h3, 16'h3333);
        check("nb_err", protocol_err, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
